ultrasonic_stop_detect: RTL and testbench

- Upstream sensor stage that produces the `stop` signal consumed by the arm/marble sequencing state machine.
- Periodically fires an ultrasonic trigger pulse and measures the echo width in clock cycles.
- Debounces near/far decisions and drives a level `stop` that is high while an obstacle is within threshold.
- Also exports the raw measurement for debug/LEDs.

---
 rtl/us_pkg.sv | 29 ++
 rtl/ultrasonic_stop_detect_if.sv | 26 ++
 rtl/us_echo_sync.sv | 33 +++
 rtl/ultrasonic_stop_detect.sv | 202 ++++++++++++++++++++
 tb/tb_ultrasonic_stop_detect.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/us_pkg.sv
// Shared definitions for the ultrasonic stop detector.
//   us_state_e      : measurement sequencer states
//   DEF_*           : default timing for a 100 MHz clk
//   CYCLES_PER_CM   : echo cycles per centimetre of range, for firmware/LED conversion
//   clog2_min1()    : counter width helper that never returns zero
package us_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLDOFF
  } us_state_e;

  localparam int unsigned DEF_TRIG_CYCLES    = 1000;
  localparam int unsigned DEF_PERIOD_CYCLES  = 6000000;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 3000000;
  localparam int unsigned DEF_STOP_THRESH    = 58000;
  localparam int unsigned DEF_CLEAR_THRESH   = 70000;
  localparam int unsigned DEF_DEBOUNCE_N     = 3;

  localparam int unsigned CYCLES_PER_CM = 5800;

  function automatic int clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/ultrasonic_stop_detect_if.sv
// Sensor/controller bundle of the ultrasonic stop detector.
//   enable, echo                      : driven by the master (system side / sensor)
//   trig, stop, echo_width,
//   meas_valid, meas_timeout          : driven by the slave (detector)
// W must equal $clog2(TIMEOUT_CYCLES+1) of the attached detector.
interface ultrasonic_stop_detect_if #(
  parameter int W = 22
);
  logic         enable;
  logic         echo;
  logic         trig;
  logic         stop;
  logic [W-1:0] echo_width;
  logic         meas_valid;
  logic         meas_timeout;

  modport master (
    output enable, echo,
    input  trig, stop, echo_width, meas_valid, meas_timeout
  );

  modport slave (
    input  enable, echo,
    output trig, stop, echo_width, meas_valid, meas_timeout
  );
endinterface

// File: rtl/us_echo_sync.sv
// Two-flop synchronizer for the asynchronous echo input plus edge pulses.
//   clk, reset_n : clock, synchronous active-low reset
//   echo         : raw sensor echo
//   echo_s       : synchronized echo level
//   rise, fall   : one-cycle pulses on echo_s edges
module us_echo_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic echo,
  output logic echo_s,
  output logic rise,
  output logic fall
);
  logic meta_q;
  logic sync_q;
  logic dly_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= echo;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign echo_s = sync_q;
  assign rise   = sync_q & ~dly_q;
  assign fall   = ~sync_q & dly_q;
endmodule

// File: rtl/ultrasonic_stop_detect.sv
// Ultrasonic obstacle detector: fires periodic trigger pulses, measures echo
// width in clk cycles and debounces near/far results into a stop level.
//   clk, reset_n : clock, synchronous active-low reset
//   bus (slave)  : enable/echo in; trig, stop, echo_width, meas_valid,
//                  meas_timeout out
// Build option US_HYST_EN: widths between STOP_THRESH and CLEAR_THRESH leave
// the debounce counters untouched; otherwise anything not near is far.
//
// state     | meaning
// IDLE      | disabled, trig low
// TRIG      | trig high for TRIG_CYCLES
// WAIT_RISE | waiting for echo rise, bounded by TIMEOUT_CYCLES
// MEASURE   | counting echo high time
// HOLDOFF   | waiting out the rest of the trigger period
module ultrasonic_stop_detect
  import us_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int unsigned PERIOD_CYCLES  = DEF_PERIOD_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned STOP_THRESH    = DEF_STOP_THRESH,
  parameter int unsigned CLEAR_THRESH   = DEF_CLEAR_THRESH,
  parameter int unsigned DEBOUNCE_N     = DEF_DEBOUNCE_N
) (
  input  logic clk,
  input  logic reset_n,
  ultrasonic_stop_detect_if.slave bus
);
  localparam int W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW = clog2_min1(TRIG_CYCLES);
  localparam int PW = clog2_min1(PERIOD_CYCLES);
  localparam int DW = clog2_min1(DEBOUNCE_N + 1);

  localparam logic [W-1:0]  TIMEOUT_W   = W'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TRIG_LOAD   = TW'(TRIG_CYCLES - 1);
  localparam logic [PW-1:0] PERIOD_LOAD = PW'(PERIOD_CYCLES - 1);
  localparam logic [DW-1:0] DEB_N       = DW'(DEBOUNCE_N);

  us_state_e     state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [DW-1:0] near_q, near_d, far_q, far_d;
  logic          stop_q, stop_d;
  logic [W-1:0]  width_q, width_d;
  logic          tmo_q, tmo_d;
  logic          valid_q, valid_d;

  logic          res_en, res_tmo;
  logic [W-1:0]  res_width;
  logic [31:0]   res_w32;
  logic          is_near, is_far;
  logic          echo_s, echo_rise, echo_fall;

  us_echo_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .echo    (bus.echo),
    .echo_s  (echo_s),
    .rise    (echo_rise),
    .fall    (echo_fall)
  );

  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    pcnt_d    = (pcnt_q != '0) ? pcnt_q - PW'(1) : '0;
    cnt_d     = cnt_q;
    res_en    = 1'b0;
    res_tmo   = 1'b0;
    res_width = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.enable) begin
          state_d = TRIG;
          tcnt_d  = TRIG_LOAD;
          pcnt_d  = PERIOD_LOAD;
        end
      end
      TRIG: begin
        if (tcnt_q == '0) begin
          state_d = WAIT_RISE;
          cnt_d   = '0;
        end else begin
          tcnt_d = tcnt_q - TW'(1);
        end
      end
      WAIT_RISE: begin
        if (echo_rise) begin
          state_d = MEASURE;
          cnt_d   = W'(1);
        end else if (cnt_q == TIMEOUT_W - W'(1)) begin
          res_en    = 1'b1;
          res_tmo   = 1'b1;
          res_width = TIMEOUT_W;
          state_d   = HOLDOFF;
        end else begin
          cnt_d = cnt_q + W'(1);
        end
      end
      MEASURE: begin
        // A fall on the cycle the count hits the limit is still a clean echo.
        if (echo_fall) begin
          res_en  = 1'b1;
          state_d = HOLDOFF;
        end else if (cnt_q == TIMEOUT_W) begin
          res_en    = 1'b1;
          res_tmo   = 1'b1;
          res_width = TIMEOUT_W;
          state_d   = HOLDOFF;
        end else if (echo_s) begin
          cnt_d = cnt_q + W'(1);
        end
      end
      HOLDOFF: begin
        if (pcnt_q == '0) begin
          state_d = TRIG;
          tcnt_d  = TRIG_LOAD;
          pcnt_d  = PERIOD_LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!bus.enable) begin
      state_d = IDLE;
      tcnt_d  = '0;
      pcnt_d  = '0;
      cnt_d   = '0;
      res_en  = 1'b0;
    end
  end

  assign res_w32 = 32'(res_width);

`ifdef US_HYST_EN
  assign is_near = !res_tmo && (res_w32 < STOP_THRESH);
  assign is_far  = res_tmo || (res_w32 >= CLEAR_THRESH);
`else
  assign is_near = !res_tmo && (res_w32 < STOP_THRESH);
  assign is_far  = !is_near;
`endif

  always_comb begin
    near_d  = near_q;
    far_d   = far_q;
    stop_d  = stop_q;
    width_d = width_q;
    tmo_d   = tmo_q;
    valid_d = 1'b0;
    if (res_en) begin
      valid_d = 1'b1;
      width_d = res_width;
      tmo_d   = res_tmo;
      if (is_near) begin
        far_d = '0;
        if (near_q != DEB_N) near_d = near_q + DW'(1);
        if (near_d == DEB_N) stop_d = 1'b1;
      end else if (is_far) begin
        near_d = '0;
        if (far_q != DEB_N) far_d = far_q + DW'(1);
        if (far_d == DEB_N) stop_d = 1'b0;
      end
    end
    if (!bus.enable) begin
      near_d = '0;
      far_d  = '0;
      stop_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      pcnt_q  <= '0;
      cnt_q   <= '0;
      near_q  <= '0;
      far_q   <= '0;
      stop_q  <= 1'b0;
      width_q <= '0;
      tmo_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      pcnt_q  <= pcnt_d;
      cnt_q   <= cnt_d;
      near_q  <= near_d;
      far_q   <= far_d;
      stop_q  <= stop_d;
      width_q <= width_d;
      tmo_q   <= tmo_d;
      valid_q <= valid_d;
    end
  end

  assign bus.trig         = (state_q == TRIG);
  assign bus.stop         = stop_q;
  assign bus.echo_width   = width_q;
  assign bus.meas_valid   = valid_q;
  assign bus.meas_timeout = tmo_q;
endmodule

// File: tb/tb_ultrasonic_stop_detect.sv
module tb_ultrasonic_stop_detect;
  localparam int TRIG_C   = 4;
  localparam int PERIOD_C = 200;
  localparam int TO_C     = 100;
  localparam int STOP_T   = 30;
  localparam int CLEAR_T  = 40;
  localparam int DEB_N    = 2;
  localparam int W        = $clog2(TO_C + 1);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   hist[$];
  int   exp_stop = 0;
  int   last_width = 0;

  ultrasonic_stop_detect_if #(.W(W)) bus ();

  ultrasonic_stop_detect #(
    .TRIG_CYCLES    (TRIG_C),
    .PERIOD_CYCLES  (PERIOD_C),
    .TIMEOUT_CYCLES (TO_C),
    .STOP_THRESH    (STOP_T),
    .CLEAR_THRESH   (CLEAR_T),
    .DEBOUNCE_N     (DEB_N)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Classification of one result: 1 near, -1 far, 0 in the hysteresis band.
  function automatic int classify(input int width, input bit timed_out);
    if (timed_out) return -1;
    if (width < STOP_T) return 1;
`ifdef US_HYST_EN
    if (width >= CLEAR_T) return -1;
    return 0;
`else
    return -1;
`endif
  endfunction

  // stop follows the last DEB_N decisive results when they all agree.
  task automatic model_result(input int width, input bit timed_out);
    int c;
    bit all_same;
    c = classify(width, timed_out);
    if (c != 0) hist.push_back(c);
    if (hist.size() >= DEB_N) begin
      all_same = 1'b1;
      for (int k = hist.size() - DEB_N; k < hist.size(); k++)
        if (hist[k] != c) all_same = 1'b0;
      if (c != 0 && all_same) exp_stop = (c == 1) ? 1 : 0;
    end
  endtask

  task automatic model_clear();
    hist.delete();
    exp_stop = 0;
  endtask

  // One full measurement: wait for a trigger, drive an echo of w cycles
  // starting d cycles after trig falls (w=0: no echo), check the result.
  task automatic measure(input int w, input int d, input string tag);
    int n;
    int lat;
    int pulses;
    bit seen;
    int got_w, got_t, got_s;
    int ew, et;
    n = 0;
    while (bus.trig !== 1'b1 && n < 400) begin tick(); n++; end
    check({tag, "_trig_rise"}, int'(bus.trig), 1);
    n = 0;
    while (bus.trig === 1'b1 && n < 20) begin tick(); n++; end
    check({tag, "_trig_len"}, n, TRIG_C);
    seen = 1'b0; pulses = 0; lat = -1;
    got_w = -1; got_t = -1; got_s = -1;
    for (int i = 0; i < d + w + 130; i++) begin
      bus.echo = (w > 0 && i >= d && i < d + w);
      tick();
      if (bus.meas_valid === 1'b1) begin
        pulses++;
        if (!seen) begin
          seen  = 1'b1;
          lat   = i + 1;
          got_w = int'(bus.echo_width);
          got_t = int'(bus.meas_timeout);
          got_s = int'(bus.stop);
        end
      end
      if (seen && i >= d + w + 3) break;
    end
    bus.echo = 1'b0;
    ew = (w == 0 || w > TO_C) ? TO_C : w;
    et = (w == 0 || w > TO_C) ? 1 : 0;
    model_result(ew, et[0]);
    last_width = ew;
    check({tag, "_valid_pulses"}, pulses, 1);
    check({tag, "_width"}, got_w, ew);
    check({tag, "_timeout"}, got_t, et);
    check({tag, "_stop"}, got_s, exp_stop);
    if (w == 0) check({tag, "_timeout_latency"}, lat, TO_C);
  endtask

  initial begin
    int n, t0, w, d, r, pulses;
    bus.enable = 1'b0;
    bus.echo   = 1'b0;
    reset_n    = 1'b0;
    repeat (3) tick();
    check("rst_trig", int'(bus.trig), 0);
    check("rst_stop", int'(bus.stop), 0);
    check("rst_width", int'(bus.echo_width), 0);
    check("rst_valid", int'(bus.meas_valid), 0);
    check("rst_timeout", int'(bus.meas_timeout), 0);
    reset_n = 1'b1;
    tick();

    // Trigger timing straight out of IDLE.
    bus.enable = 1'b1;
    tick();
    check("trig_start", int'(bus.trig), 1);
    t0 = cyc;
    n = 0;
    while (bus.trig === 1'b1 && n < 20) begin tick(); n++; end
    check("trig_first_len", n, TRIG_C);
    n = 0;
    while (bus.trig !== 1'b1 && n < 400) begin tick(); n++; end
    check("trig_period", cyc - t0, PERIOD_C);
    bus.enable = 1'b0;
    repeat (3) tick();
    check("disable_stop", int'(bus.stop), 0);
    model_clear();

    bus.enable = 1'b1;
    measure(20, 3, "near1");
    measure(20, 5, "near2");
    measure(50, 2, "far1");
    measure(50, 4, "far2");
    measure(10, 2, "near3");
    measure(10, 6, "near4");
    measure(35, 3, "mid1");
    measure(35, 3, "mid2");
    measure(35, 3, "mid3");
    measure(0, 0, "noecho");
    measure(150, 2, "sat");

    for (int it = 0; it < 12; it++) begin
      r = $urandom_range(0, 4);
      d = $urandom_range(1, 10);
      case (r)
        0: w = $urandom_range(1, 25);
        1: w = $urandom_range(31, 39);
        2: w = $urandom_range(45, 90);
        3: w = 0;
        default: w = $urandom_range(110, 160);
      endcase
      measure(w, d, $sformatf("rnd%0d", it));
    end

    // Drop enable in the middle of an echo with stop asserted.
    measure(5, 2, "pre_drop1");
    measure(5, 2, "pre_drop2");
    n = 0;
    while (bus.trig !== 1'b1 && n < 400) begin tick(); n++; end
    n = 0;
    while (bus.trig === 1'b1 && n < 20) begin tick(); n++; end
    bus.echo = 1'b1;
    repeat (12) tick();
    bus.enable = 1'b0;
    tick();
    check("drop_trig", int'(bus.trig), 0);
    check("drop_stop", int'(bus.stop), 0);
    bus.echo = 1'b0;
    pulses = 0;
    repeat (10) begin
      tick();
      if (bus.meas_valid === 1'b1) pulses++;
    end
    check("drop_no_result", pulses, 0);
    check("drop_width_hold", int'(bus.echo_width), last_width);
    model_clear();
    bus.enable = 1'b1;
    tick();
    check("reenable_trig", int'(bus.trig), 1);

    // Reset while trig is high.
    reset_n = 1'b0;
    tick();
    check("rst2_trig", int'(bus.trig), 0);
    check("rst2_stop", int'(bus.stop), 0);
    check("rst2_width", int'(bus.echo_width), 0);
    check("rst2_valid", int'(bus.meas_valid), 0);
    check("rst2_timeout", int'(bus.meas_timeout), 0);
    bus.enable = 1'b0;
    reset_n = 1'b1;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
